// File: rtl/cal_angle_arb.sv
// cal_angle_arb: two-requester round-robin front end for one shared cal_angle
// engine. Every issued sample pushes its owner id into a tag FIFO. Returned
// angles pop that FIFO in order and are steered back to the owning requester.
module cal_angle_arb #(
    parameter int DW        = 8,
    parameter int AW        = 16,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0_val_i,
    input  logic [DW-1:0]                 req0_real_i,
    input  logic [DW-1:0]                 req0_imag_i,
    output logic                          req0_rdy_o,
    input  logic                          req1_val_i,
    input  logic [DW-1:0]                 req1_real_i,
    input  logic [DW-1:0]                 req1_imag_i,
    output logic                          req1_rdy_o,
    output logic                          eng_val_o,
    output logic [DW-1:0]                 eng_real_o,
    output logic [DW-1:0]                 eng_imag_o,
    input  logic                          eng_val_i,
    input  logic [AW-1:0]                 eng_angle_i,
    output logic                          res0_val_o,
    output logic [AW-1:0]                 res0_angle_o,
    output logic                          res1_val_o,
    output logic [AW-1:0]                 res1_angle_o,
    output logic [$clog2(TAG_DEPTH):0]    inflight_o,
    output logic                          err_o
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    // Arbitration state and issue registers
    logic                 last_grant_reg;
    logic                 eng_val_reg;
    logic [DW-1:0]        eng_real_reg;
    logic [DW-1:0]        eng_imag_reg;

    // Tag FIFO: one owner bit per in-flight sample
    logic                 tag_mem [TAG_DEPTH];
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        inflight_reg;
    logic                 err_reg;

    // Result channels
    logic                 res_val_reg   [2];
    logic [AW-1:0]        res_angle_reg [2];

    logic                 credit_ok;
    logic                 grant0;
    logic                 grant1;
    logic                 rdy0;
    logic                 rdy1;
    logic                 issue;
    logic                 winner;
    logic                 fifo_empty;
    logic                 pop;
    logic                 pop_tag;

    // Full/empty come from the occupancy count, so pointer equality never
    // has to be disambiguated.
    assign credit_ok  = (inflight_reg < CW'(TAG_DEPTH));
    assign fifo_empty = (inflight_reg == '0);

    // A lone requester always wins; on contention the one that did not win
    // last time gets the slot. last_grant_reg resets to 1 so requester 0
    // wins the first contended cycle.
    assign grant0 = req0_val_i & (~req1_val_i | last_grant_reg);
    assign grant1 = req1_val_i & (~req0_val_i | ~last_grant_reg);

    assign rdy0   = grant0 & credit_ok & rst_n;
    assign rdy1   = grant1 & credit_ok & rst_n;
    assign issue  = rdy0 | rdy1;
    assign winner = rdy1;

    assign pop     = eng_val_i & ~fifo_empty;
    assign pop_tag = tag_mem[rd_ptr_reg];

    assign req0_rdy_o = rdy0;
    assign req1_rdy_o = rdy1;

    // Issue path: forward the winner's sample to the engine one cycle later;
    // priority only rotates when something is actually issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_val_reg    <= 1'b0;
            eng_real_reg   <= '0;
            eng_imag_reg   <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            eng_val_reg <= issue;
            if (issue) begin
                eng_real_reg   <= winner ? req1_real_i : req0_real_i;
                eng_imag_reg   <= winner ? req1_imag_i : req0_imag_i;
                last_grant_reg <= winner;
            end
        end
    end

    // Tag storage: written on issue; contents need no reset because the
    // occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr_reg] <= winner;
        end
    end

    // FIFO pointers (wrap naturally at the power-of-two depth), occupancy
    // count and the sticky error for returns that match no outstanding tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({issue, pop})
                2'b10:   inflight_reg <= inflight_reg + CW'(1);
                2'b01:   inflight_reg <= inflight_reg - CW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
            if (eng_val_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Per-channel result registers: a one-cycle valid pulse for the owner of
    // the popped tag; the angle holds between results.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_res
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    res_val_reg[gi]   <= 1'b0;
                    res_angle_reg[gi] <= '0;
                end else begin
                    res_val_reg[gi] <= pop && (pop_tag == 1'(gi));
                    if (pop && (pop_tag == 1'(gi))) begin
                        res_angle_reg[gi] <= eng_angle_i;
                    end
                end
            end
        end
    endgenerate

    assign eng_val_o    = eng_val_reg;
    assign eng_real_o   = eng_real_reg;
    assign eng_imag_o   = eng_imag_reg;
    assign res0_val_o   = res_val_reg[0];
    assign res0_angle_o = res_angle_reg[0];
    assign res1_val_o   = res_val_reg[1];
    assign res1_angle_o = res_angle_reg[1];
    assign inflight_o   = inflight_reg;
    assign err_o        = err_reg;

endmodule
